wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port stall, input, 1, hold the stage register when high.
REQ-004 SHALL have port flush, input, 1, load a bubble (all-zero instruction) when high.
REQ-005 SHALL have port ex_instruction, input, 32, instruction leaving execute.
REQ-006 SHALL have port ex_pc, input, 32, PC of ex_instruction.
REQ-007 SHALL have port ex_alu_out, input, 32, ALU result, which is also the data-memory address for loads.
REQ-008 SHALL have port dmem_dout, input, 32, synchronous data-memory read word, valid in the cycle after the address.
REQ-009 SHALL have port wb_instruction, output, 32, registered instruction, used for forwarding compare.
REQ-010 SHALL have port wb_rf_we, output, 1, register-file write enable.
REQ-011 SHALL have port wb_rd, output, 5, destination register, equal to wb_instruction[11:7].
REQ-012 SHALL have port wb_data, output, 32, write-back value, also the forwarded operand to execute.
REQ-013 SHALL have port instret, output, 32, retired-instruction count (see Configuration).

Function
REQ-014 SHALL register ex_instruction, ex_pc and ex_alu_out on each clk edge when stall=0 and flush=0.
REQ-015 SHALL load instruction=0, pc=0, alu=0 when flush=1, regardless of stall; flush beats stall.
REQ-016 SHALL keep all stage registers unchanged when stall=1 and flush=0.
REQ-017 SHALL compute wb_data combinationally from registered values, with zero further latency:
- LUI: {instr[31:12],12'b0}
- JAL/JALR: pc+4, mod 2^32
- LOAD: aligned dmem_dout
- all other opcodes: alu.
REQ-018 SHALL align load data as follows:
- LB/LBU: byte alu[1:0]*8, sign- or zero-extended.
- LH/LHU: halfword at alu[1]*16, sign- or zero-extended; alu[0] ignored.
- LW: full word; alu[1:0] ignored.
- Unknown load funct3: full word.
REQ-019 SHALL assert wb_rf_we only for R-type, I-type arith, LOAD, JAL, JALR, LUI, AUIPC with wb_rd≠0.
REQ-020 SHALL hold wb_rf_we=0 for STORE, BRANCH, opcode 0, any unknown opcode, or rd=0; wb_data still follows the REQ-017 default.

Reset
REQ-021 SHALL, on rst=1 at a clk edge, clear instruction, pc, alu and instret to 0; this gives wb_rf_we=0, wb_rd=0, wb_data=0.
REQ-022 SHALL give rst priority over flush and stall, including mid-stall.

Configuration
REQ-023 SHALL compile the retire counter only when macro WB_INSTRET_EN is defined.
REQ-024 SHALL, with WB_INSTRET_EN, increment instret by 1 on each edge where rst=0, stall=0 and the registered opcode≠0.
REQ-025 SHALL, with WB_INSTRET_EN, wrap instret from 0xFFFFFFFF to 0.
REQ-026 SHALL, without WB_INSTRET_EN, drive instret constant 0 and infer no counter flops.

Verification
REQ-027 SHALL cover: LB, alu=0x1003, dmem_dout=0x80112233 -> wb_data=0xFFFFFF80, wb_rf_we=1.
REQ-028 SHALL cover: LHU, alu=0x1003, dmem_dout=0x80112233 -> wb_data=0x00008011; LH same -> 0xFFFF8011.
REQ-029 SHALL cover: JAL rd=x1, pc=0xFFFFFFFC -> wb_data=0x00000000, wb_rf_we=1; ADDI rd=x0 -> wb_rf_we=0.
REQ-030 SHALL cover: stall=1 and flush=1 together with a valid ADD -> next cycle wb_instruction=0, wb_rf_we=0; stall alone for 3 cycles -> outputs held.
REQ-031 SHALL cover: rst=1 during stall with a LUI held -> next cycle all outputs 0, instret=0.
REQ-032 SHALL cover, with WB_INSTRET_EN: instret preset by forcing 0xFFFFFFFE, then 2 non-stalled ADDs -> instret=0; without the macro, instret stays 0.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: write-back pipeline stage.
// Registers the instruction, PC and ALU result leaving execute, then forms the
// register-file write value and write enable combinationally from them.
// Optional feature: define WB_INSTRET_EN to build the retired-instruction
// counter; without it, instret is tied to zero and no counter flops exist.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] ex_instruction,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] dmem_dout,
    output logic [31:0] wb_instruction,
    output logic        wb_rf_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [31:0] instret
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [31:0] alu_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Stage register: reset beats flush, flush beats stall.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            pc_q    <= '0;
            alu_q   <= '0;
        end else if (flush) begin
            instr_q <= '0;
            pc_q    <= '0;
            alu_q   <= '0;
        end else if (!stall) begin
            instr_q <= ex_instruction;
            pc_q    <= ex_pc;
            alu_q   <= ex_alu_out;
        end
    end

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];

    // Load alignment: select the addressed byte/halfword of the read word and extend it.
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        ld_byte = dmem_dout[7:0];
        ld_half = alu_q[1] ? dmem_dout[31:16] : dmem_dout[15:0];
        ld_data = dmem_dout;
        case (alu_q[1:0])
            2'd1:    ld_byte = dmem_dout[15:8];
            2'd2:    ld_byte = dmem_dout[23:16];
            2'd3:    ld_byte = dmem_dout[31:24];
            default: ld_byte = dmem_dout[7:0];
        endcase
        case (funct3)
            F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            F3_LBU:  ld_data = {24'h0, ld_byte};
            F3_LHU:  ld_data = {16'h0, ld_half};
            default: ld_data = dmem_dout;
        endcase
    end

    // Write-back value and enable, decoded from the registered opcode.
    always_comb begin
        wb_data  = alu_q;
        wb_rf_we = 1'b0;
        case (opcode)
            OP_LUI: begin
                wb_data  = {instr_q[31:12], 12'h000};
                wb_rf_we = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                wb_data  = pc_q + 32'd4;
                wb_rf_we = 1'b1;
            end
            OP_LOAD: begin
                wb_data  = ld_data;
                wb_rf_we = 1'b1;
            end
            OP_REG, OP_IMM, OP_AUIPC: begin
                wb_rf_we = 1'b1;
            end
            default: begin
                wb_rf_we = 1'b0;
            end
        endcase
        // Writes to x0 are discarded.
        if (instr_q[11:7] == 5'd0) begin
            wb_rf_we = 1'b0;
        end
    end

    assign wb_instruction = instr_q;
    assign wb_rd          = instr_q[11:7];

`ifdef WB_INSTRET_EN
    logic [31:0] instret_q;

    // Retire counter: counts each non-stalled edge with a real instruction in the stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (!stall && (opcode != 7'd0)) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage.
// The driver applies one set of inputs per cycle, advances a behavioural model
// of the stage and queues the outputs expected after the next edge; a monitor
// pops one entry per cycle and compares it with the DUT.
// Build with WB_INSTRET_EN defined to exercise the retire counter.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] ex_instruction;
    logic [31:0] ex_pc;
    logic [31:0] ex_alu_out;
    logic [31:0] dmem_dout;
    logic [31:0] wb_instruction;
    logic        wb_rf_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] instret;

    wb_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .ex_instruction (ex_instruction),
        .ex_pc          (ex_pc),
        .ex_alu_out     (ex_alu_out),
        .dmem_dout      (dmem_dout),
        .wb_instruction (wb_instruction),
        .wb_rf_we       (wb_rf_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .instret        (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] instr;
        logic        rf_we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] count;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model state: the architectural contents of the stage.
    logic [31:0] m_instr   = '0;
    logic [31:0] m_pc      = '0;
    logic [31:0] m_alu     = '0;
    logic [31:0] m_instret = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
        return {12'h000, 5'd1, f3, rd, op};
    endfunction

    // Reference write-back value, from the instruction-set rules.
    function automatic logic [31:0] ref_data(input logic [31:0] ins, input logic [31:0] pc,
                                             input logic [31:0] alu, input logic [31:0] dm);
        logic [31:0] v;
        int          sh;
        case (ins[6:0])
            7'b0110111: return {ins[31:12], 12'h000};
            7'b1101111,
            7'b1100111: return pc + 32'd4;
            7'b0000011: begin
                case (ins[14:12])
                    3'b000, 3'b100: begin
                        sh = 8 * int'(alu[1:0]);
                        v  = (dm >> sh) & 32'hFF;
                        if (ins[14:12] == 3'b000 && v[7]) v = v | 32'hFFFFFF00;
                        return v;
                    end
                    3'b001, 3'b101: begin
                        sh = 16 * int'(alu[1]);
                        v  = (dm >> sh) & 32'hFFFF;
                        if (ins[14:12] == 3'b001 && v[15]) v = v | 32'hFFFF0000;
                        return v;
                    end
                    default: return dm;
                endcase
            end
            default: return alu;
        endcase
    endfunction

    function automatic logic ref_we(input logic [31:0] ins);
        logic writes;
        writes = ins[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
                                  7'b1100111, 7'b0110111, 7'b0010111};
        return writes && (ins[11:7] != 5'd0);
    endfunction

    // One cycle of stimulus: drive inputs, advance the model, queue expectations.
    // When ovr is set, the expected write-back value is the given constant.
    task automatic step(input string tag, input logic r, input logic s, input logic f,
                        input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] dm, input bit ovr, input logic [31:0] ovr_data);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; flush = f;
        ex_instruction = ins; ex_pc = pc; ex_alu_out = alu; dmem_dout = dm;
        if (r) begin
            m_instr = '0; m_pc = '0; m_alu = '0; m_instret = '0;
        end else begin
            if (!s && m_instr[6:0] != 7'd0) m_instret = m_instret + 32'd1;
            if (f) begin
                m_instr = '0; m_pc = '0; m_alu = '0;
            end else if (!s) begin
                m_instr = ins; m_pc = pc; m_alu = alu;
            end
        end
        e.tag   = tag;
        e.instr = m_instr;
        e.rf_we = ref_we(m_instr);
        e.rd    = m_instr[11:7];
        e.data  = ovr ? ovr_data : ref_data(m_instr, m_pc, m_alu, dm);
`ifdef WB_INSTRET_EN
        e.count = m_instret;
`else
        e.count = 32'd0;
`endif
        exp_q.push_back(e);
    endtask

    // Monitor: one queued expectation per cycle, compared after the edge settles.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, " instr"},   wb_instruction,     e.instr);
                check({e.tag, " rf_we"},   {31'd0, wb_rf_we},  {31'd0, e.rf_we});
                check({e.tag, " rd"},      {27'd0, wb_rd},     {27'd0, e.rd});
                check({e.tag, " data"},    wb_data,            e.data);
                check({e.tag, " instret"}, instret,            e.count);
            end
        end
    end

    localparam logic [6:0] OPS [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
                                        7'b1100111, 7'b0110111, 7'b0010111, 7'b0100011,
                                        7'b1100011, 7'b0000000};

    initial begin
        logic [31:0] add_x3, lui_x4;
        int          budget;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        ex_instruction = '0; ex_pc = '0; ex_alu_out = '0; dmem_dout = '0;
        add_x3 = mk(7'b0110011, 3'b000, 5'd3);
        lui_x4 = {20'hABCDE, 5'd4, 7'b0110111};

        step("reset", 1, 0, 0, add_x3, 32'h100, 32'h55, 32'h0, 1, 32'h0);
        step("reset2", 1, 1, 1, add_x3, 32'h100, 32'h55, 32'h0, 1, 32'h0);

        // Load alignment corner cases.
        step("lb",  0, 0, 0, mk(7'b0000011, 3'b000, 5'd5), 32'h200, 32'h1003, 32'h80112233, 1, 32'hFFFFFF80);
        step("lhu", 0, 0, 0, mk(7'b0000011, 3'b101, 5'd5), 32'h204, 32'h1003, 32'h80112233, 1, 32'h00008011);
        step("lh",  0, 0, 0, mk(7'b0000011, 3'b001, 5'd5), 32'h208, 32'h1003, 32'h80112233, 1, 32'hFFFF8011);
        step("lw",  0, 0, 0, mk(7'b0000011, 3'b010, 5'd5), 32'h20C, 32'h1003, 32'h80112233, 1, 32'h80112233);

        // PC+4 wrap and x0 destination.
        step("jal_wrap", 0, 0, 0, mk(7'b1101111, 3'b000, 5'd1), 32'hFFFFFFFC, 32'h7, 32'h0, 1, 32'h0);
        step("addi_x0",  0, 0, 0, mk(7'b0010011, 3'b000, 5'd0), 32'h210, 32'h1234, 32'h0, 1, 32'h1234);

        // Flush beats stall, then a 3-cycle stall holds an ADD.
        step("add",         0, 0, 0, add_x3, 32'h300, 32'hCAFE, 32'h0, 1, 32'hCAFE);
        step("stall_flush", 0, 1, 1, add_x3, 32'h304, 32'hBEEF, 32'h0, 1, 32'h0);
        step("add2",        0, 0, 0, add_x3, 32'h308, 32'h1111, 32'h0, 1, 32'h1111);
        for (int i = 0; i < 3; i++)
            step("stall_hold", 0, 1, 0, mk(7'b0010011, 3'b000, 5'd9), 32'h30C, 32'h2222, 32'h0, 1, 32'h1111);

        // Reset while stalled with a LUI held.
        step("lui",       0, 0, 0, lui_x4, 32'h400, 32'h0, 32'h0, 1, 32'hABCDE000);
        step("lui_stall", 0, 1, 0, add_x3, 32'h404, 32'h9, 32'h0, 1, 32'hABCDE000);
        step("rst_stall", 1, 1, 0, add_x3, 32'h408, 32'h9, 32'h0, 1, 32'h0);

`ifdef WB_INSTRET_EN
        // Preset the counter near wrap and retire two ADDs.
        step("add_pre", 0, 0, 0, add_x3, 32'h500, 32'h1, 32'h0, 0, 32'h0);
        @(posedge clk);
        #3;
        force dut.instret_q = 32'hFFFFFFFE;
        #1;
        release dut.instret_q;
        m_instret = 32'hFFFFFFFE;
        step("add_w1", 0, 0, 0, add_x3, 32'h504, 32'h2, 32'h0, 0, 32'h0);
        step("add_w2", 0, 0, 0, add_x3, 32'h508, 32'h3, 32'h0, 0, 32'h0);
        step("wrap",   0, 1, 0, add_x3, 32'h50C, 32'h4, 32'h0, 0, 32'h0);
        check("instret_wrap", instret, 32'h0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ins;
            ins      = $urandom;
            ins[6:0] = ($urandom_range(0, 15) == 0) ? 7'b1111111 : OPS[$urandom_range(0, 9)];
            step("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0), ins, $urandom, $urandom, $urandom, 0, 32'h0);
        end

        // Let the monitor drain the queue, with a bound.
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("drain_left", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
